stream_packer: RTL

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer_pkg.sv | 23 ++
 rtl/stream_packer_rotator.sv | 38 +++
 rtl/stream_packer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stream_packer_pkg.sv
// Shared types and helpers for the stream packer: FSM state encoding and
// a tkeep popcount that turns a keep mask into a byte count.
package stream_packer_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Widest tkeep the popcount helper accepts; narrower masks are zero-extended.
  localparam int MAX_BYTES = 128;

  // Number of set bits in a tkeep mask (the valid byte count of a beat).
  function automatic int unsigned keep_count(input logic [MAX_BYTES-1:0] keep);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      c += 32'(keep[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/stream_packer_rotator.sv
// Left byte-rotation of a beat by a variable byte amount, built from
// log2(BYTES) conditional shift stages with an optional output register.
module byte_rotator #(
  parameter int BYTES      = 64,
  parameter bit REGISTERED = 1'b0
) (
  input  logic                       clk,
  input  logic [BYTES*8-1:0]         data,
  input  logic [$clog2(BYTES)-1:0]   amount,
  output logic [BYTES*8-1:0]         rotated
);

  localparam int WIDTH = BYTES * 8;
  localparam int SHW   = $clog2(BYTES);

  logic [WIDTH-1:0] stage [0:SHW];

  assign stage[0] = data;

  // Stage s rotates byte k up to byte k + 2^s when amount bit s is set.
  for (genvar s = 0; s < SHW; s++) begin : g_stage
    localparam int SB = (1 << s) * 8;
    assign stage[s+1] = amount[s] ? {stage[s][WIDTH-1-SB:0], stage[s][WIDTH-1:WIDTH-SB]}
                                  : stage[s];
  end

  if (REGISTERED) begin : g_reg
    // Optional pipeline register on the rotated result.
    always_ff @(posedge clk) begin
      rotated <= stage[SHW];
    end
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk;
    assign rotated    = stage[SHW];
  end

endmodule

// File: rtl/stream_packer.sv
// Packs sparse AXI4-Stream beats (contiguous tkeep from byte 0) into dense
// output beats, preserving byte order and packet boundaries.
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int WIDTH     = 512,
  parameter int BYTES     = WIDTH / 8,
  parameter int CNT_WIDTH = $clog2(BYTES) + 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [WIDTH-1:0]     i_data_tdata,
  input  logic [BYTES-1:0]     i_data_tkeep,
  input  logic                 i_data_tlast,
  input  logic                 i_data_tvalid,
  output logic                 i_data_tready,
  output logic [WIDTH-1:0]     o_data_tdata,
  output logic [BYTES-1:0]     o_data_tkeep,
  output logic                 o_data_tlast,
  output logic                 o_data_tvalid,
  input  logic                 o_data_tready,
  output logic [CNT_WIDTH-1:0] o_fill
);

  localparam int SHW = $clog2(BYTES);
  localparam int SW  = CNT_WIDTH + 1;

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] fill;
  logic [CNT_WIDTH-1:0] fill_next;
  logic [WIDTH-1:0]     buffer;
  logic [WIDTH-1:0]     rotated;
  logic [WIDTH-1:0]     merged;
  logic [SW-1:0]        n;
  logic [SW-1:0]        sum;
  logic [BYTES-1:0]     sum_mask;
  logic [BYTES-1:0]     fill_mask;
  logic                 out_free;
  logic                 accept;
  logic                 emit;
  logic                 emit_buf;
  logic                 emit_last;
  logic [BYTES-1:0]     emit_keep;
  logic                 buf_load;
  logic                 buf_rot;

  byte_rotator #(
    .BYTES      (BYTES),
    .REGISTERED (1'b0)
  ) u_rotator (
    .clk     (aclk),
    .data    (i_data_tdata),
    .amount  (fill[SHW-1:0]),
    .rotated (rotated)
  );

  assign out_free      = !o_data_tvalid || o_data_tready;
  assign i_data_tready = aresetn && (state == RUN) && out_free;
  assign accept        = i_data_tvalid && i_data_tready;
  assign n             = SW'(keep_count(MAX_BYTES'(i_data_tkeep)));
  assign sum           = SW'(fill) + n;
  assign o_fill        = fill;

  // Keep masks for the combined byte count and for the held bytes, plus the
  // merge of held bytes (below fill) with the rotated input (from fill up).
  always_comb begin
    sum_mask  = '0;
    fill_mask = '0;
    merged    = '0;
    for (int j = 0; j < BYTES; j++) begin
      sum_mask[j]      = (SW'(j) < sum);
      fill_mask[j]     = (CNT_WIDTH'(j) < fill);
      merged[8*j +: 8] = fill_mask[j] ? buffer[8*j +: 8] : rotated[8*j +: 8];
    end
  end

  // Decide what this cycle does: flush the residue, emit a beat, or just merge.
  always_comb begin
    emit       = 1'b0;
    emit_buf   = 1'b0;
    emit_last  = 1'b0;
    emit_keep  = '1;
    buf_load   = 1'b0;
    buf_rot    = 1'b0;
    fill_next  = fill;
    state_next = state;
    if (state == FLUSH) begin
      if (out_free) begin
        emit       = 1'b1;
        emit_buf   = 1'b1;
        emit_last  = 1'b1;
        emit_keep  = fill_mask;
        fill_next  = '0;
        state_next = RUN;
      end
    end else if (accept) begin
      if (i_data_tlast && (sum <= SW'(BYTES))) begin
        emit      = 1'b1;
        emit_last = 1'b1;
        emit_keep = sum_mask;
        fill_next = '0;
      end else if (sum >= SW'(BYTES)) begin
        emit      = 1'b1;
        buf_load  = 1'b1;
        buf_rot   = 1'b1;
        fill_next = CNT_WIDTH'(sum - SW'(BYTES));
        if (i_data_tlast) begin
          state_next = FLUSH;
        end
      end else begin
        buf_load  = 1'b1;
        fill_next = CNT_WIDTH'(sum);
      end
    end
  end

  // Control state: FSM state, fill level and output valid, cleared by reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= RUN;
      fill          <= '0;
      o_data_tvalid <= 1'b0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
      if (emit) begin
        o_data_tvalid <= 1'b1;
      end else if (o_data_tready) begin
        o_data_tvalid <= 1'b0;
      end
    end
  end

  // Datapath registers: staging buffer and output beat, intentionally not reset.
  always_ff @(posedge aclk) begin
    if (buf_load) begin
      buffer <= buf_rot ? rotated : merged;
    end
    if (emit) begin
      o_data_tdata <= emit_buf ? buffer : merged;
      o_data_tkeep <= emit_keep;
      o_data_tlast <= emit_last;
    end
  end

endmodule
